// File: rtl/conv3x3_mac_engine_if.sv
// Bus bundle for conv3x3_mac_engine: window taps and valid, serial
// coefficient load port, load status flags and filtered-pixel output.
// master = upstream window generator / coefficient source, slave = engine.
interface conv3x3_mac_engine_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] Data_In1;
  logic [DATA_WIDTH-1:0] Data_In2;
  logic [DATA_WIDTH-1:0] Data_In3;
  logic [DATA_WIDTH-1:0] Data_In4;
  logic [DATA_WIDTH-1:0] Data_In5;
  logic [DATA_WIDTH-1:0] Data_In6;
  logic [DATA_WIDTH-1:0] Data_In7;
  logic [DATA_WIDTH-1:0] Data_In8;
  logic [DATA_WIDTH-1:0] Data_In9;
  logic                  Valid_In;
  logic                  Start_Load;
  logic [DATA_WIDTH-1:0] Coef_In;
  logic                  Coef_Valid;
  logic                  Coef_Ready;
  logic                  Weights_Ready;
  logic [DATA_WIDTH-1:0] Data_Out;
  logic                  Valid_Out;

  modport master (
    output Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
    output Data_In6, Data_In7, Data_In8, Data_In9,
    output Valid_In, Start_Load, Coef_In, Coef_Valid,
    input  Coef_Ready, Weights_Ready, Data_Out, Valid_Out
  );

  modport slave (
    input  Data_In1, Data_In2, Data_In3, Data_In4, Data_In5,
    input  Data_In6, Data_In7, Data_In8, Data_In9,
    input  Valid_In, Start_Load, Coef_In, Coef_Valid,
    output Coef_Ready, Weights_Ready, Data_Out, Valid_Out
  );
endinterface

// File: rtl/conv3x3_mac_engine.sv
// conv3x3_mac_engine: fixed-point 3x3 convolution MAC with a serially
// loaded, double-banked kernel (W1..W9 + bias). 4-stage pipeline:
// products -> 5 partial sums -> full sum -> round/shift/saturate/ReLU.
// Optional build macro: CONV3X3_MAC_RELU_EN clamps negative results to 0.
module conv3x3_mac_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input logic                  clk,
  input logic                  rst,
  conv3x3_mac_engine_if.slave  bus
);

  localparam int PW        = 2 * DATA_WIDTH;      // full product width
  localparam int AW        = 2 * DATA_WIDTH + 4;  // accumulator width
  localparam int NUM_TAPS  = 9;
  localparam int NUM_WORDS = 10;                  // 9 weights + bias
  localparam int BIAS_IDX  = NUM_WORDS - 1;

  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

  localparam logic signed [AW-1:0] HALF    = AW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state, state_next;

  logic [3:0] cnt;
  logic       load_word;
  logic       commit;
  logic       coef_ready;
  logic       weights_ready;

  logic signed [DATA_WIDTH-1:0] staging [NUM_WORDS];
  logic signed [DATA_WIDTH-1:0] active  [NUM_WORDS];
  logic signed [DATA_WIDTH-1:0] taps    [NUM_TAPS];

  logic accept;
  logic v1, v2, v3;

  logic signed [PW-1:0]         prod [NUM_TAPS];
  logic signed [PW-1:0]         bias_s1;
  logic signed [AW-1:0]         psum [5];
  logic signed [AW-1:0]         sum_s3;
  logic signed [AW-1:0]         rounded;
  logic signed [AW-1:0]         shifted;
  logic signed [DATA_WIDTH-1:0] result;

  assign taps[0] = bus.Data_In1;
  assign taps[1] = bus.Data_In2;
  assign taps[2] = bus.Data_In3;
  assign taps[3] = bus.Data_In4;
  assign taps[4] = bus.Data_In5;
  assign taps[5] = bus.Data_In6;
  assign taps[6] = bus.Data_In7;
  assign taps[7] = bus.Data_In8;
  assign taps[8] = bus.Data_In9;

  assign bus.Coef_Ready    = coef_ready;
  assign bus.Weights_Ready = weights_ready;

  // Windows are taken whenever a kernel exists, independent of load state.
  assign accept = bus.Valid_In & weights_ready;

  // FSM state register.
  // NOTE: every clocked process uses non-blocking (<=) so all registers
  // update together from pre-edge values; blocking here would create
  // order-dependent races between processes.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and load strobes; Start_Load wins over any word.
  // NOTE: each output gets a default before the branches so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    commit     = 1'b0;
    if (bus.Start_Load) begin
      state_next = LOAD;
    end else if (state == LOAD && bus.Coef_Valid) begin
      load_word = 1'b1;
      if (cnt == LAST_WORD) begin
        commit     = 1'b1;
        state_next = RUN;
      end
    end
  end

  // Word counter, staging/active banks and status flags.
  // NOTE: the coefficient banks are reset because a cleared kernel is part
  // of the reset contract; the pipeline data registers below are not, since
  // their valid bits already mask them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      coef_ready    <= 1'b0;
      weights_ready <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        staging[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      coef_ready <= (state_next == LOAD);
      if (bus.Start_Load) begin
        cnt <= '0;
      end else if (load_word) begin
        staging[cnt] <= bus.Coef_In;
        if (commit) begin
          // Commit the full bank, including the bias arriving this cycle.
          for (int i = 0; i < NUM_WORDS - 1; i++) active[i] <= staging[i];
          active[BIAS_IDX] <= bus.Coef_In;
          weights_ready    <= 1'b1;
          cnt              <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  // Valid shift chain for stages S1..S3; no stall, so it shifts every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // S1: full-width products against the bank visible before this edge,
  // so a window on the commit edge still sees the old kernel.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TAPS; i++) prod[i] <= PW'(taps[i]) * PW'(active[i]);
    bias_s1 <= PW'(active[BIAS_IDX]) <<< FRAC_BITS;
  end

  // S2: five pairwise partial sums in the guarded accumulator width.
  always_ff @(posedge clk) begin
    psum[0] <= AW'(prod[0]) + AW'(prod[1]);
    psum[1] <= AW'(prod[2]) + AW'(prod[3]);
    psum[2] <= AW'(prod[4]) + AW'(prod[5]);
    psum[3] <= AW'(prod[6]) + AW'(prod[7]);
    psum[4] <= AW'(prod[8]) + AW'(bias_s1);
  end

  // S3: full sum of the tree.
  always_ff @(posedge clk) begin
    sum_s3 <= psum[0] + psum[1] + psum[2] + psum[3] + psum[4];
  end

  // S4 combinational part: round half up, rescale, saturate, optional ReLU.
  always_comb begin
    rounded = sum_s3 + HALF;
    shifted = rounded >>> FRAC_BITS;
    if (shifted > SAT_MAX)      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                        result = shifted[DATA_WIDTH-1:0];
`ifdef CONV3X3_MAC_RELU_EN
    if (result[DATA_WIDTH-1]) result = '0;
`else
    result = result;
`endif
  end

  // S4 register: output is held at zero whenever it is not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Valid_Out <= 1'b0;
      bus.Data_Out  <= '0;
    end else begin
      bus.Valid_Out <= v3;
      bus.Data_Out  <= v3 ? result : '0;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_engine.sv
// Self-checking bench for conv3x3_mac_engine: directed vector table from the
// test plan, reload-while-streaming, reset mid-load, and randomized traffic
// checked every cycle against a cycle-stepped behavioural model.
module tb_conv3x3_mac_engine;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst;

  conv3x3_mac_engine_if #(.DATA_WIDTH(32)) bus ();

  conv3x3_mac_engine #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0][31:0] w;
    logic [8:0][31:0] tap;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [5];

  int n_err;
  int n_chk;
  int cyc;
  int n_vout;
  int n_old;

  // Behavioural model state
  logic [9:0][31:0] m_act;
  logic [9:0][31:0] m_stg;
  int               m_cnt;
  bit               m_loading;
  bit               m_ready;
  logic [31:0]      slot_data [8];
  bit               slot_vld  [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference convolution from plain arithmetic on wide integers.
  function automatic logic [31:0] ref_conv(input logic [8:0][31:0] t, input logic [9:0][31:0] w);
    logic signed [67:0] acc;
    logic signed [67:0] rnd;
    logic signed [31:0] a;
    logic signed [31:0] b;
    logic [31:0]        r;
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      a   = t[i];
      b   = w[i];
      acc = acc + 68'(a) * 68'(b);
    end
    b   = w[9];
    acc = acc + 68'(b) * 68'sd65536;
    rnd = (acc + 68'sd32768) >>> 16;
    if (rnd > 68'sh7FFF_FFFF)       r = 32'h7FFF_FFFF;
    else if (rnd < -68'sh8000_0000) r = 32'h8000_0000;
    else                            r = rnd[31:0];
`ifdef CONV3X3_MAC_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  function automatic logic [8:0][31:0] cur_taps();
    logic [8:0][31:0] t;
    t[0] = bus.Data_In1; t[1] = bus.Data_In2; t[2] = bus.Data_In3;
    t[3] = bus.Data_In4; t[4] = bus.Data_In5; t[5] = bus.Data_In6;
    t[6] = bus.Data_In7; t[7] = bus.Data_In8; t[8] = bus.Data_In9;
    return t;
  endfunction

  task automatic set_taps(input logic [8:0][31:0] t);
    bus.Data_In1 = t[0]; bus.Data_In2 = t[1]; bus.Data_In3 = t[2];
    bus.Data_In4 = t[3]; bus.Data_In5 = t[4]; bus.Data_In6 = t[5];
    bus.Data_In7 = t[6]; bus.Data_In8 = t[7]; bus.Data_In9 = t[8];
  endtask

  function automatic logic [31:0] small_val();
    return 32'($urandom_range(0, 32'h3FFFF)) - 32'h20000;
  endfunction

  task automatic rand_taps(input bit wide);
    logic [8:0][31:0] t;
    for (int i = 0; i < 9; i++) t[i] = wide ? 32'($urandom) : small_val();
    set_taps(t);
  endtask

  task automatic idle();
    bus.Valid_In   = 1'b0;
    bus.Start_Load = 1'b0;
    bus.Coef_Valid = 1'b0;
  endtask

  // Advance one clock: update the model with the inputs about to be
  // sampled, step the DUT, then compare every output.
  task automatic tick();
    int s;
    if (rst) begin
      m_act = '0; m_stg = '0; m_cnt = 0; m_loading = 0; m_ready = 0;
      for (int i = 0; i < 8; i++) slot_vld[i] = 0;
    end else begin
      if (bus.Valid_In && m_ready) begin
        slot_data[(cyc + 4) % 8] = ref_conv(cur_taps(), m_act);
        slot_vld[(cyc + 4) % 8]  = 1;
      end
      if (bus.Start_Load) begin
        m_loading = 1;
        m_cnt     = 0;
      end else if (m_loading && bus.Coef_Valid) begin
        m_stg[m_cnt] = bus.Coef_In;
        if (m_cnt == 9) begin
          m_act     = m_stg;
          m_ready   = 1;
          m_loading = 0;
          m_cnt     = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    s = cyc % 8;
    if (bus.Valid_Out === 1'b1) n_vout++;
    check("valid_out", 32'(bus.Valid_Out), 32'(slot_vld[s]));
    check("data_out", bus.Data_Out, slot_vld[s] ? slot_data[s] : 32'h0);
    check("coef_ready", 32'(bus.Coef_Ready), 32'(m_loading));
    check("weights_ready", 32'(bus.Weights_Ready), 32'(m_ready));
    slot_vld[s] = 0;
  endtask

  task automatic load_kernel(input logic [9:0][31:0] w, input bit gaps);
    bus.Start_Load = 1'b1;
    tick();
    bus.Start_Load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        bus.Coef_Valid = 1'b0;
        tick();
      end
      bus.Coef_Valid = 1'b1;
      bus.Coef_In    = w[i];
      tick();
    end
    bus.Coef_Valid = 1'b0;
    tick();
  endtask

  initial begin
    logic [9:0][31:0] w;
    logic [8:0][31:0] t;
    int               word;

    n_err = 0; n_chk = 0; cyc = 0; n_vout = 0; n_old = 0;
    m_act = '0; m_stg = '0; m_cnt = 0; m_loading = 0; m_ready = 0;
    for (int i = 0; i < 8; i++) begin slot_vld[i] = 0; slot_data[i] = '0; end

    // Directed vectors from the test plan
    for (int i = 0; i < 9; i++) begin
      vecs[0].w[i] = ONE;          vecs[0].tap[i] = 32'h0002_0000;
      vecs[1].w[i] = 32'h0;        vecs[1].tap[i] = small_val();
      vecs[3].w[i] = 32'h7FFF_0000; vecs[3].tap[i] = 32'h7FFF_0000;
      vecs[4].w[i] = 32'h7FFF_0000; vecs[4].tap[i] = 32'h8000_0000;
    end
    vecs[0].w[9] = 32'h0;          vecs[0].exp = 32'h0012_0000;
    vecs[1].w[0] = 32'h0000_8000;  vecs[1].w[9] = ONE;
    vecs[1].tap[0] = 32'h0000_0001; vecs[1].exp = 32'h0001_0001;
    vecs[2] = vecs[1];
    vecs[2].tap[0] = 32'hFFFF_FFFF; vecs[2].exp = 32'h0001_0000;
    vecs[3].w[9] = 32'h0;          vecs[3].exp = 32'h7FFF_FFFF;
    vecs[4].w[9] = 32'h0;
`ifdef CONV3X3_MAC_RELU_EN
    vecs[4].exp = 32'h0000_0000;
`else
    vecs[4].exp = 32'h8000_0000;
`endif

    idle();
    bus.Coef_In = '0;
    set_taps('0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_data_out", bus.Data_Out, 32'h0);
    check("reset_weights_ready", 32'(bus.Weights_Ready), 32'h0);

    // Windows before any kernel is loaded are dropped
    bus.Valid_In = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_taps(0); tick(); end
    bus.Valid_In = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("drop_no_output", 32'(n_vout), 32'h0);

    // Table-driven single windows: output exactly four edges later
    for (int v = 0; v < 5; v++) begin
      load_kernel(vecs[v].w, v[0]);
      set_taps(vecs[v].tap);
      bus.Valid_In = 1'b1;
      tick();
      bus.Valid_In = 1'b0;
      rand_taps(1);
      tick(); tick(); tick();
      check("vec_valid", 32'(bus.Valid_Out), 32'h1);
      check("vec_data", bus.Data_Out, vecs[v].exp);
      tick();
    end

    // Reload 1.0 -> 2.0 while streaming 20 back-to-back windows
    for (int i = 0; i < 9; i++) w[i] = ONE;
    w[9] = 32'h0;
    load_kernel(w, 0);
    for (int i = 0; i < 9; i++) begin w[i] = 32'h0002_0000; t[i] = ONE; end
    set_taps(t);
    n_vout = 0;
    word   = 0;
    for (int k = 0; k < 20; k++) begin
      bus.Valid_In   = 1'b1;
      bus.Start_Load = (k == 1);
      bus.Coef_Valid = 1'b0;
      if (k >= 2 && (k % 3) != 0 && word < 10) begin
        bus.Coef_Valid = 1'b1;
        bus.Coef_In    = w[word];
        word++;
      end
      tick();
      if (bus.Valid_Out === 1'b1 && bus.Data_Out === 32'h0009_0000) n_old++;
    end
    idle();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.Valid_Out === 1'b1 && bus.Data_Out === 32'h0009_0000) n_old++;
    end
    check("reload_out_count", 32'(n_vout), 32'd20);
    check("reload_old_kernel_count", 32'(n_old), 32'd17);

    // Reset after word 5 of a load with windows in flight
    bus.Start_Load = 1'b1;
    tick();
    bus.Start_Load = 1'b0;
    bus.Valid_In   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_taps(0);
      bus.Coef_Valid = 1'b1;
      bus.Coef_In    = small_val();
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid_out", 32'(bus.Valid_Out), 32'h0);
    check("rst_weights_ready", 32'(bus.Weights_Ready), 32'h0);
    bus.Coef_Valid = 1'b0;
    tick(); tick();
    bus.Valid_In = 1'b0;
    for (int i = 0; i < 10; i++) w[i] = small_val();
    load_kernel(w, 1);
    check("reload_weights_ready", 32'(bus.Weights_Ready), 32'h1);
    bus.Valid_In = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_taps(0); tick(); end
    idle();
    for (int i = 0; i < 5; i++) tick();

    // Randomized traffic: loads, restarts, stray words, windows, resets
    for (int k = 0; k < 400; k++) begin
      bus.Start_Load = ($urandom_range(0, 39) == 0);
      bus.Coef_Valid = $urandom_range(0, 1);
      bus.Coef_In    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : small_val();
      bus.Valid_In   = $urandom_range(0, 1);
      rand_taps($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    for (int i = 0; i < 6; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/conv3x3_mac_engine.md
# conv3x3_mac_engine

Fixed-point 3x3 convolution datapath that consumes the nine window taps produced each cycle by the 3x3/stride-1/padding-1 window generator and emits one filtered pixel per accepted window. It holds one 3x3 kernel plus bias, loaded through a serial coefficient port. The datapath is a 4-stage pipelined multiply/adder tree with rounding and saturation. It sits directly downstream of the window generator and feeds the next layer stage or the feature-map writer.

## Interface
- DATA_WIDTH, 32: width of pixels, coefficients, bias and result, signed two's complement.
- FRAC_BITS, 16: fractional bits of the fixed-point format, shared by pixels, coefficients, bias and result.
- clk  input  1  the single clock.
- rst  input  1  synchronous, active-high reset.
- Data_In1..Data_In9  input  DATA_WIDTH each  window taps, row-major; 1 = top-left, 9 = bottom-right; padded taps arrive as 0.
- Valid_In  input  1  window valid; taps sampled on the same edge.
- Start_Load  input  1  single-cycle pulse that begins a coefficient load.
- Coef_In  input  DATA_WIDTH  coefficient word.
- Coef_Valid  input  1  Coef_In valid.
- Coef_Ready  output  1  high while in LOAD.
- Weights_Ready  output  1  an active kernel has been committed since reset.
- Data_Out  output  DATA_WIDTH  filtered pixel.
- Valid_Out  output  1  Data_Out valid.

## Operation
- FSM states: IDLE, LOAD, RUN.
  - Reset → IDLE.
  - Start_Load in any state → LOAD, and the word counter is cleared to 0.
  - In LOAD, each cycle with Coef_Valid=1 writes Coef_In to staging[cnt] and increments cnt.
  - Load order is W1..W9, then bias (10 words).
  - Acceptance of word 10 (cnt=9) copies the whole staging bank into the active bank in that cycle, sets Weights_Ready=1, and moves the FSM → RUN.
- Coef_Valid outside LOAD: ignored.
- Start_Load during LOAD: restarts at word 0. Staging contents are overwritten; the active bank is untouched.
- Valid_In is accepted whenever Weights_Ready=1, in any state, including during a reload, which uses the old active bank. Valid_In with Weights_Ready=0 is dropped; no output is produced.
- Commit-cycle rule: a window accepted on the same edge as the commit uses the OLD bank. The next window uses the new bank.
- Arithmetic:
  - P_i = Data_In_i × W_i, full 2·DATA_WIDTH-bit signed product, Q.2F.
  - The bias is sign-extended and shifted left by FRAC_BITS to align with the products.
  - Accumulator width is 2·DATA_WIDTH+4; no overflow is possible inside the tree.
- Pipeline stages:
  - S1: register the 9 products and the aligned bias.
  - S2: register 5 partial sums: (P1+P2), (P3+P4), (P5+P6), (P7+P8), (P9+bias).
  - S3: register the full sum.
  - S4: round-half-up by adding 2^(FRAC_BITS−1), arithmetic shift right by FRAC_BITS, saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], apply optional ReLU, then register to Data_Out.
- Per-stage valid bits shift every cycle; there is no stall and no backpressure.
- Data_Out is forced to 0 in any cycle where Valid_Out=0.
- Reset values:
  - Data_Out=0, Valid_Out=0, Coef_Ready=0, Weights_Ready=0.
  - Active and staging banks are all 0, cnt=0, and all pipeline valid bits are 0.

## Timing
- Latency: Valid_In sampled at edge N → Valid_Out high and Data_Out valid after edge N+4.
- Throughput: one window per cycle; back-to-back Valid_In produces back-to-back Valid_Out.
- Coef_Ready is registered from the state: it rises the cycle after Start_Load and falls the cycle after word 10 is accepted.
- Weights_Ready rises the cycle after word 10 is accepted.
- rst mid-operation:
  - All in-flight results are discarded and Valid_Out=0 from the next cycle.
  - The load is aborted, the banks are cleared and Weights_Ready=0.
- Start_Load and Coef_Valid on the same edge: the FSM enters LOAD and the word is ignored. The word count starts on the next edge.

## Configuration
- CONV3X3_MAC_RELU_EN defined: S4 replaces any negative saturated result with 0.
- CONV3X3_MAC_RELU_EN undefined: the signed saturated result passes unchanged.
- Latency is 4 cycles in both builds.

## Test plan
- **Basic sum:** FRAC_BITS=16; load W1..W9=0x00010000, bias=0; one window with all taps 0x00020000 → Data_Out=0x00120000 with Valid_Out exactly 4 cycles later; Data_Out=0 in every other cycle.
- **Rounding and bias:** W1=0x00008000, W2..W9=0, bias=0x00010000; Data_In1=0x00000001 → 0x00010001 (the half-LSB rounds up). Repeat with Data_In1=0xFFFFFFFF → 0x00010000.
- **Saturation and ReLU:**
  - All W=0x7FFF0000, all taps 0x7FFF0000 → 0x7FFFFFFF.
  - All taps 0x80000000 → 0x80000000 without CONV3X3_MAC_RELU_EN, and 0x00000000 with it.
- **Reload during stream:**
  - Stream 20 windows continuously while reloading the weights from 1.0 to 2.0 (0x00020000) with gaps in Coef_Valid.
  - Windows accepted up to and including the commit edge use 1.0; later windows use 2.0.
  - No Valid_Out bubble occurs.
- **Not-ready drop and reset:**
  - Valid_In before any load → no Valid_Out.
  - Assert rst after word 5 of a load and during in-flight windows → Valid_Out=0 and Weights_Ready=0 from the next cycle.
  - A subsequent full load works with cnt restarting at 0.
